psola_ola_stream: RTL and testbench

- Next-generation pitch-shift synthesis engine. Streams WINDOW_SIZE output samples per analysis window by triangular-windowed overlap-add (OLA) of grains.
- Analysis period Tp and synthesis period Tt are runtime inputs. Up to MAX_GRAINS grains may overlap at each output sample.
- Reads source samples from an external ping-pong sample RAM through a fixed-latency read port.
- Emits signed samples over a valid/ready handshake to the downstream audio path.

---
 rtl/psola_ola_stream.sv | 241 ++++++++++++++++++++++++
 tb/tb_psola_ola_stream.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psola_ola_stream.sv
// Overlap-add pitch-synthesis engine: per output sample, walks the active
// triangular-windowed grains, reads their source samples and sums the weighted data.
module psola_ola_stream #(
   parameter int WIDTH        = 16,
   parameter int WINDOW_SIZE  = 2048,
   parameter int PERIOD_WIDTH = 12,
   parameter int FRAC         = 10,
   parameter int MAX_GRAINS   = 4,
   parameter int READ_LATENCY = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         start_in,
   input  logic                         bank_in,
   input  logic [PERIOD_WIDTH-1:0]      period_in,
   input  logic [PERIOD_WIDTH-1:0]      target_period_in,
   input  logic [FRAC:0]                inv_period_in,
   output logic                         rd_en_out,
   output logic [$clog2(WINDOW_SIZE):0] rd_addr_out,
   input  logic signed [WIDTH-1:0]      rd_data_in,
   output logic signed [WIDTH-1:0]      sample_out,
   output logic                         sample_valid_out,
   input  logic                         sample_ready_in,
   output logic                         busy_out,
   output logic                         done_out,
   output logic                         err_out
);
   localparam int AW   = $clog2(WINDOW_SIZE);
   localparam int IW   = PERIOD_WIDTH + AW;
   localparam int WW   = FRAC + 1;
   localparam int PRW  = IW + WW;
   localparam int GW   = $clog2(MAX_GRAINS + 1);
   localparam int ACCW = WIDTH + $clog2(MAX_GRAINS) + 1;
   localparam int MW   = WIDTH + WW + 1;
   localparam int RL   = READ_LATENCY;

   localparam logic [IW-1:0]          WIN_LAST = IW'(WINDOW_SIZE - 1);
   localparam logic [IW-1:0]          WIN_SIZE = IW'(WINDOW_SIZE);
   localparam logic [PRW-1:0]         W_ONE    = PRW'(1) << FRAC;
   localparam logic [GW-1:0]          G_MAX    = GW'(MAX_GRAINS);
   localparam logic signed [ACCW-1:0] SAT_MAX  = ACCW'((1 << (WIDTH - 1)) - 1);
   localparam logic signed [ACCW-1:0] SAT_MIN  = -ACCW'(1 << (WIDTH - 1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t state, state_d;

   logic                   bank_q;
   logic [PERIOD_WIDTH-1:0] tp_q, tt_q;
   logic [WW-1:0]          inv_q;
   logic [IW-1:0]          n, s_lo, b_lo, s_cur, b_cur;
   logic [GW-1:0]          g_cnt;
   logic signed [ACCW-1:0] acc;
   logic                   err_q;

   // Side pipeline that travels with each read: valid, contributes, weight.
   logic                   pipe_v [RL];
   logic                   pipe_u [RL];
   logic [WW-1:0]          pipe_w [RL];

   logic [IW-1:0]          start_tp2, start_cap;
   logic                   start_bad;
   logic [IW-1:0]          tp2_q, o_off, src_idx, w_dist, n_inc;
   logic [PRW-1:0]         w_prod;
   logic [WW-1:0]          w_clamp;
   logic                   grain_ok, in_range, issue, adv, pipe_busy;
   logic signed [MW-1:0]   mul_full;
   logic signed [ACCW-1:0] acc_add;
   logic signed [WIDTH-1:0] sat_val;

   always_comb begin
      start_tp2 = IW'(period_in) << 1;
      start_cap = IW'(target_period_in) * IW'(MAX_GRAINS);
      start_bad = (period_in == '0) || (target_period_in == '0) || (start_tp2 > start_cap);
   end

   // Grain walk: grains at or after k_lo that have started are all still active,
   // because k_lo retires at most one expired grain per output sample.
   always_comb begin
      tp2_q    = IW'(tp_q) << 1;
      o_off    = n - s_cur;
      src_idx  = b_cur + o_off;
      grain_ok = (s_cur <= n) && (g_cnt < G_MAX);
      in_range = src_idx < WIN_SIZE;
      if (o_off < IW'(tp_q)) begin
         w_dist = o_off;
      end else begin
         w_dist = tp2_q - o_off;
      end
      w_prod  = PRW'(w_dist) * PRW'(inv_q);
      w_clamp = (w_prod > W_ONE) ? W_ONE[WW-1:0] : w_prod[WW-1:0];
      n_inc   = n + IW'(1);
      adv     = n_inc >= (s_lo + tp2_q);
   end

   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 0; i < RL; i++) begin
         pipe_busy = pipe_busy | pipe_v[i];
      end
      mul_full = MW'(rd_data_in) * MW'($signed({1'b0, pipe_w[RL-1]}));
      acc_add  = ACCW'(mul_full >>> FRAC);
      if (acc > SAT_MAX) begin
         sat_val = {1'b0, {(WIDTH-1){1'b1}}};
      end else if (acc < SAT_MIN) begin
         sat_val = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         sat_val = acc[WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state <= S_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // Output handshake: a sample transfers on a cycle where sample_valid_out and
   // sample_ready_in are both 1; until then sample_out and valid hold steady.
   always_comb begin
      state_d          = state;
      issue            = 1'b0;
      sample_valid_out = 1'b0;
      busy_out         = 1'b0;
      done_out         = 1'b0;
      case (state)
         S_IDLE: begin
            if (start_in && !start_bad) state_d = S_ISSUE;
         end
         S_ISSUE: begin
            busy_out = 1'b1;
            if (grain_ok) begin
               issue = 1'b1;
            end else if (g_cnt == '0) begin
               state_d = S_EMIT;
            end else begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy_out = 1'b1;
            if (!pipe_busy) state_d = S_EMIT;
         end
         S_EMIT: begin
            busy_out         = 1'b1;
            sample_valid_out = 1'b1;
            if (sample_ready_in) state_d = (n == WIN_LAST) ? S_DONE : S_ISSUE;
         end
         S_DONE: begin
            done_out = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rd_en_out   = issue && in_range;
      rd_addr_out = rd_en_out ? {bank_q, src_idx[AW-1:0]} : '0;
      sample_out  = sample_valid_out ? sat_val : '0;
      err_out     = err_q;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         bank_q <= 1'b0;
         tp_q   <= '0;
         tt_q   <= '0;
         inv_q  <= '0;
         n      <= '0;
         s_lo   <= '0;
         b_lo   <= '0;
         s_cur  <= '0;
         b_cur  <= '0;
         g_cnt  <= '0;
         acc    <= '0;
         err_q  <= 1'b0;
         for (int i = 0; i < RL; i++) begin
            pipe_v[i] <= 1'b0;
            pipe_u[i] <= 1'b0;
            pipe_w[i] <= '0;
         end
      end else begin
         err_q     <= (state == S_IDLE) && start_in && start_bad;
         pipe_v[0] <= issue;
         pipe_u[0] <= issue && in_range;
         pipe_w[0] <= w_clamp;
         for (int i = 1; i < RL; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_u[i] <= pipe_u[i-1];
            pipe_w[i] <= pipe_w[i-1];
         end
         if (state == S_IDLE && start_in) begin
            bank_q <= bank_in;
            tp_q   <= period_in;
            tt_q   <= target_period_in;
            inv_q  <= inv_period_in;
            if (!start_bad) begin
               n     <= '0;
               s_lo  <= '0;
               b_lo  <= '0;
               s_cur <= '0;
               b_cur <= '0;
               g_cnt <= '0;
               acc   <= '0;
            end
         end
         if (issue) begin
            s_cur <= s_cur + IW'(tt_q);
            b_cur <= b_cur + IW'(tp_q);
            g_cnt <= g_cnt + GW'(1);
         end
         if (pipe_v[RL-1] && pipe_u[RL-1]) begin
            acc <= acc + acc_add;
         end
         // Retire the oldest grain for the next sample before the walk restarts.
         if (state == S_EMIT && sample_ready_in) begin
            acc   <= '0;
            n     <= n_inc;
            g_cnt <= '0;
            if (adv) begin
               s_lo  <= s_lo + IW'(tt_q);
               b_lo  <= b_lo + IW'(tp_q);
               s_cur <= s_lo + IW'(tt_q);
               b_cur <= b_lo + IW'(tp_q);
            end else begin
               s_cur <= s_lo;
               b_cur <= b_lo;
            end
         end
      end
   end
endmodule

// File: tb/tb_psola_ola_stream.sv
// Randomised scoreboard bench for psola_ola_stream: a grain-by-grain arithmetic
// model queues expected samples, read addresses, read counts and latencies.
module tb_psola_ola_stream;
   localparam int WS  = 64;
   localparam int RL  = 2;
   localparam int TMO = 8000;

   logic               clk_in, rst_n_in, start_in, bank_in;
   logic [11:0]        period_in, target_period_in;
   logic [10:0]        inv_period_in;
   logic               rd_en_out;
   logic [6:0]         rd_addr_out;
   logic signed [15:0] rd_data_in, sample_out;
   logic               sample_valid_out, sample_ready_in, busy_out, done_out, err_out;

   logic signed [15:0] mem [2][WS];
   logic signed [15:0] rpipe [RL];

   logic [15:0] exp_q[$];
   logic [6:0]  addr_q[$];
   int          cnt_q[$];
   int          lat_q[$];

   int          checks, errors, cyc, mark, rd_cnt, win_n, stall_cnt;
   bit          done_exp, prev_valid, prev_ready, rand_ready, stall_req;
   logic [15:0] prev_sample;

   psola_ola_stream #(
      .WIDTH(16), .WINDOW_SIZE(WS), .PERIOD_WIDTH(12), .FRAC(10),
      .MAX_GRAINS(4), .READ_LATENCY(RL)
   ) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .bank_in(bank_in),
      .period_in(period_in), .target_period_in(target_period_in),
      .inv_period_in(inv_period_in), .rd_en_out(rd_en_out), .rd_addr_out(rd_addr_out),
      .rd_data_in(rd_data_in), .sample_out(sample_out), .sample_valid_out(sample_valid_out),
      .sample_ready_in(sample_ready_in), .busy_out(busy_out), .done_out(done_out),
      .err_out(err_out)
   );

   // clock / reset
   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // fixed-latency RAM; idle slots return junk the DUT must ignore
   always @(posedge clk_in) begin
      if (rd_en_out) rpipe[0] <= mem[rd_addr_out[6]][rd_addr_out[5:0]];
      else           rpipe[0] <= 16'($urandom);
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
   end
   assign rd_data_in = rpipe[RL-1];

   // downstream ready driver
   initial begin
      sample_ready_in = 1'b0;
      forever begin
         @(posedge clk_in); #1;
         if (stall_req && sample_valid_out && win_n == 5 && stall_cnt < 10) begin
            sample_ready_in = 1'b0;
            stall_cnt++;
         end else if (rand_ready) begin
            sample_ready_in = ($urandom_range(0, 3) != 0);
         end else begin
            sample_ready_in = 1'b1;
         end
      end
   end

   task automatic flush_q();
      exp_q.delete(); addr_q.delete(); cnt_q.delete(); lat_q.delete();
   endtask

   // reference: direct sum over grain index k using the window definition
   task automatic model_window(input bit b, input int tp, input int tt, input int inv);
      int acc, g, rc, s, o, idx, w;
      for (int n = 0; n < WS; n++) begin
         acc = 0; g = 0; rc = 0;
         for (int k = 0; k * tt <= n; k++) begin
            s = k * tt;
            if (n < s + 2 * tp) begin
               o   = n - s;
               idx = k * tp + o;
               g++;
               if (idx < WS) begin
                  w = (o < tp) ? o * inv : (2 * tp - o) * inv;
                  if (w > 1024) w = 1024;
                  acc += (int'(mem[b][idx]) * w) >>> 10;
                  addr_q.push_back({b, 6'(idx)});
                  rc++;
               end
            end
         end
         if (acc > 32767) acc = 32767;
         if (acc < -32768) acc = -32768;
         exp_q.push_back(16'(acc));
         cnt_q.push_back(rc);
         lat_q.push_back((g == 0) ? 2 : g + RL + 2);
      end
   endtask

   task automatic fill_const(input bit b, input int v);
      for (int i = 0; i < WS; i++) mem[b][i] = 16'(v);
   endtask

   task automatic fill_rand(input bit b);
      for (int i = 0; i < WS; i++) mem[b][i] = 16'($urandom);
   endtask

   task automatic fill_ramp(input bit b);
      for (int i = 0; i < WS; i++) mem[b][i] = 16'(i);
   endtask

   task automatic do_start(input bit b, input int tp, input int tt, input int inv);
      bit ok;
      ok = (tp != 0) && (tt != 0) && (2 * tp <= 4 * tt);
      if (ok) model_window(b, tp, tt, inv);
      @(posedge clk_in); #1;
      bank_in = b; period_in = 12'(tp); target_period_in = 12'(tt);
      inv_period_in = 11'(inv); start_in = 1'b1;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (err_out !== !ok || busy_out !== ok) begin
         errors++;
         $display("FAIL start_response tp=%0d tt=%0d err=%b busy=%b want err=%b busy=%b",
                  tp, tt, err_out, busy_out, !ok, ok);
      end
      if (!ok) begin
         repeat (4) begin
            @(negedge clk_in);
            checks++;
            if (rd_en_out || busy_out || err_out) begin
               errors++;
               $display("FAIL reject_quiet rd_en=%b busy=%b err=%b want 0 0 0",
                        rd_en_out, busy_out, err_out);
            end
         end
      end
   endtask

   task automatic wait_done();
      bit seen;
      seen = 0;
      for (int i = 0; i < TMO && !seen; i++) begin
         @(negedge clk_in);
         if (done_out) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL window_timeout done=0 want 1 within %0d cycles", TMO);
      end
      repeat (2) @(negedge clk_in);
   endtask

   task automatic wait_win(input int target);
      int i;
      i = 0;
      while (win_n < target && i < TMO) begin
         @(negedge clk_in);
         i++;
      end
      checks++;
      if (win_n < target) begin
         errors++;
         $display("FAIL win_progress n=%0d want %0d", win_n, target);
      end
   endtask

   // start pulse during a busy window must be ignored without an error
   task automatic busy_poke();
      repeat (30) @(negedge clk_in);
      @(posedge clk_in); #1;
      start_in = 1'b1; period_in = '0;
      @(posedge clk_in); #1;
      start_in = 1'b0;
      @(negedge clk_in);
      checks++;
      if (err_out || !busy_out) begin
         errors++;
         $display("FAIL busy_start err=%b busy=%b want 0 1", err_out, busy_out);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk_in) begin
      cyc++;
      if (!rst_n_in) begin
         checks++;
         if (rd_en_out || rd_addr_out != 0 || sample_out != 0 || sample_valid_out ||
             busy_out || done_out || err_out) begin
            errors++;
            $display("FAIL reset_outputs rd_en=%b addr=%h smp=%h vld=%b busy=%b done=%b err=%b want all 0",
                     rd_en_out, rd_addr_out, sample_out, sample_valid_out, busy_out, done_out, err_out);
         end
         flush_q();
         rd_cnt = 0; win_n = 0; done_exp = 0; prev_valid = 0; prev_ready = 0;
      end else begin
         if (done_exp) begin
            checks++;
            if (!done_out) begin
               errors++;
               $display("FAIL done_pulse done=%b want 1", done_out);
            end
            done_exp = 0;
         end else if (done_out) begin
            checks++; errors++;
            $display("FAIL done_spurious done=1 want 0 (win_n=%0d)", win_n);
         end
         if (start_in && !busy_out && !done_out) begin
            mark = cyc; win_n = 0; rd_cnt = 0;
         end
         if (rd_en_out) begin
            rd_cnt++;
            checks++;
            if (addr_q.size() == 0) begin
               errors++;
               $display("FAIL rd_addr unexpected read addr=%h want none", rd_addr_out);
            end else begin
               logic [6:0] ea;
               ea = addr_q.pop_front();
               if (rd_addr_out != ea || sample_valid_out) begin
                  errors++;
                  $display("FAIL rd_addr got=%h want=%h (valid=%b want 0)", rd_addr_out, ea, sample_valid_out);
               end
            end
         end
         if (sample_valid_out && !prev_valid) begin
            checks++;
            if (lat_q.size() == 0) begin
               errors++;
               $display("FAIL latency unexpected valid, want none");
            end else begin
               int el;
               el = lat_q.pop_front();
               if (cyc - mark != el) begin
                  errors++;
                  $display("FAIL latency n=%0d got=%0d want=%0d", win_n, cyc - mark, el);
               end
            end
         end
         if (prev_valid && !prev_ready) begin
            checks++;
            if (!sample_valid_out || sample_out != prev_sample) begin
               errors++;
               $display("FAIL hold vld=%b smp=%h want vld=1 smp=%h", sample_valid_out, sample_out, prev_sample);
            end
         end
         if (sample_valid_out && sample_ready_in) begin
            checks++;
            if (exp_q.size() == 0 || cnt_q.size() == 0) begin
               errors++;
               $display("FAIL sample unexpected got=%h want none", sample_out);
            end else begin
               logic [15:0] es;
               int ec;
               es = exp_q.pop_front();
               ec = cnt_q.pop_front();
               if (sample_out != es || rd_cnt != ec || rd_cnt > 4) begin
                  errors++;
                  $display("FAIL sample n=%0d got=%0d reads=%0d want=%0d reads=%0d",
                           win_n, $signed(sample_out), rd_cnt, $signed(es), ec);
               end
            end
            rd_cnt = 0; mark = cyc; win_n++;
            if (win_n == WS) done_exp = 1;
         end
         prev_valid  = sample_valid_out;
         prev_ready  = sample_ready_in;
         prev_sample = sample_out;
      end
   end

   // stimulus
   initial begin
      int tp, tt, inv;
      checks = 0; errors = 0; cyc = 0; mark = 0; rd_cnt = 0; win_n = 0;
      rand_ready = 0; stall_req = 0; stall_cnt = 0;
      rst_n_in = 1'b0; start_in = 1'b0; bank_in = 1'b0;
      period_in = '0; target_period_in = '0; inv_period_in = '0;
      fill_rand(0); fill_rand(1);
      repeat (3) @(negedge clk_in);
      @(posedge clk_in); #1 rst_n_in = 1'b1;

      fill_const(0, 1000);
      do_start(0, 8, 8, 128);
      wait_done();

      fill_const(0, 20000);
      do_start(0, 8, 4, 128);
      wait_done();

      do_start(0, 8, 3, 128);
      do_start(0, 0, 5, 128);
      do_start(0, 5, 0, 0);

      fill_rand(0);
      stall_req = 1; stall_cnt = 0;
      do_start(0, 8, 8, 128);
      wait_done();
      stall_req = 0;
      checks++;
      if (stall_cnt != 10) begin
         errors++;
         $display("FAIL stall_len got=%0d want=10", stall_cnt);
      end

      rand_ready = 1;
      fill_ramp(1); fill_rand(0);
      do_start(1, 12, 8, 85);
      busy_poke();
      wait_done();

      fill_rand(0);
      do_start(0, 8, 6, 128);
      wait_win(20);
      @(posedge clk_in); #1 rst_n_in = 1'b0;
      flush_q();
      @(posedge clk_in); #1 rst_n_in = 1'b1;
      repeat (4) @(negedge clk_in);
      do_start(0, 8, 8, 128);
      wait_done();

      do_start(0, 3, 10, 341);
      wait_done();

      for (int r = 0; r < 5; r++) begin
         bit b;
         b  = 1'($urandom);
         tp = $urandom_range(1, 16);
         tt = $urandom_range(1, 20);
         inv = ($urandom_range(0, 1) != 0) ? (1024 + tp / 2) / tp : $urandom_range(0, 2047);
         fill_rand(b);
         do_start(b, tp, tt, inv);
         if (2 * tp <= 4 * tt) wait_done();
      end

      checks++;
      if (exp_q.size() != 0 || addr_q.size() != 0) begin
         errors++;
         $display("FAIL leftover samples=%0d reads=%0d want 0 0", exp_q.size(), addr_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
